// File: rtl/yarp_lsu.sv
// rtl/yarp_lsu.sv - load/store unit: execute-stage access to req/gnt/rvalid data bus
module yarp_lsu #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_req_i,
  input  logic              lsu_wr_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_zero_extnd_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Captured request
  logic [ADDR_W-1:0] base_q;
  logic [OFFW-1:0]   off_q;
  logic [3:0]        nbytes_q;
  logic              wr_q;
  logic              zext_q;
  logic              split_q;
  logic              err_q;
  logic [2*NB-1:0]   be_q;
  logic [XLEN-1:0]   wdata_q;
  // Beat 0 read data in the low half, beat 1 in the high half
  logic [2*XLEN-1:0] buf_q;

  // Request decode, evaluated against the live inputs in IDLE
  logic [OFFW-1:0]   off_c;
  logic [3:0]        nbytes_c;
  logic              size_bad_c;
  logic              split_c;
  logic              err_c;
  logic [NB-1:0]     mask_c;
  logic [2*NB-1:0]   be_wide_c;
  logic [OFFW+2:0]   wsh_c;
  logic [XLEN-1:0]   wrot_c;
  logic [ADDR_W-1:0] base_c;

  // Decode size, lane offset, split and error from the incoming request
  always_comb begin
    off_c      = lsu_addr_i[OFFW-1:0];
    size_bad_c = 1'b0;
    case (lsu_size_i)
      2'b00:   nbytes_c = 4'd1;
      2'b01:   nbytes_c = 4'd2;
      2'b11:   nbytes_c = 4'd4;
      default: begin
        nbytes_c   = 4'd8;
        size_bad_c = (XLEN == 32);
      end
    endcase
    split_c = (int'(off_c) + int'(nbytes_c)) > NB;
    err_c   = size_bad_c || (split_c && !ALLOW_MISALIGNED);
    mask_c  = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(nbytes_c)) mask_c[i] = 1'b1;
    end
    // Low NB bits are beat-0 enables, high NB bits are beat-1 enables
    be_wide_c = {{NB{1'b0}}, mask_c} << off_c;
    wsh_c     = {off_c, 3'b000};
    wrot_c    = (lsu_wdata_i << wsh_c) | (lsu_wdata_i >> (XLEN - int'(wsh_c)));
    base_c    = {lsu_addr_i[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; rvalid only matters in WAITx, gnt only in REQx
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (lsu_req_i) state_d = err_c ? S_RESP : S_REQ0;
      S_REQ0:  if (mem_gnt_i) state_d = S_WAIT0;
      S_WAIT0: if (mem_rvalid_i) state_d = split_q ? S_REQ1 : S_RESP;
      S_REQ1:  if (mem_gnt_i) state_d = S_WAIT1;
      S_WAIT1: if (mem_rvalid_i) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request on acceptance and collect read beats
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q   <= '0;
      off_q    <= '0;
      nbytes_q <= '0;
      wr_q     <= 1'b0;
      zext_q   <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lsu_req_i) begin
            base_q   <= base_c;
            off_q    <= off_c;
            nbytes_q <= nbytes_c;
            wr_q     <= lsu_wr_i;
            zext_q   <= lsu_zero_extnd_i;
            split_q  <= split_c;
            err_q    <= err_c;
            be_q     <= be_wide_c;
            wdata_q  <= wrot_c;
            buf_q    <= '0;
          end
        end
        S_WAIT0: if (mem_rvalid_i) buf_q[XLEN-1:0] <= mem_rdata_i;
        S_WAIT1: if (mem_rvalid_i) buf_q[2*XLEN-1:XLEN] <= mem_rdata_i;
        default: ;
      endcase
    end
  end

  // Load result: shift collected bytes down to bit 0, then extend from the top byte
  logic [OFFW+2:0] rsh;
  logic [XLEN-1:0] ld_val;
  logic            ld_fill;
  logic [XLEN-1:0] ld_ext;

  // Align and sign/zero-extend the collected load data
  always_comb begin
    rsh    = {off_q, 3'b000};
    ld_val = XLEN'(buf_q >> rsh);
    case (nbytes_q)
      4'd1:    ld_fill = ld_val[7];
      4'd2:    ld_fill = ld_val[15];
      4'd4:    ld_fill = ld_val[31];
      default: ld_fill = ld_val[XLEN-1];
    endcase
    if (zext_q) ld_fill = 1'b0;
    ld_ext = '0;
    for (int i = 0; i < XLEN; i++) begin
      ld_ext[i] = (i < 8 * int'(nbytes_q)) ? ld_val[i] : ld_fill;
    end
  end

  // Outputs decoded from state; bus fields are zero outside REQx
  always_comb begin
    lsu_busy_o  = (state_q != S_IDLE);
    lsu_done_o  = (state_q == S_RESP);
    lsu_err_o   = (state_q == S_RESP) && err_q;
    lsu_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if ((state_q == S_RESP) && !wr_q && !err_q) lsu_rdata_o = ld_ext;
    if (state_q == S_REQ0) begin
      mem_req_o   = 1'b1;
      mem_we_o    = wr_q;
      mem_addr_o  = base_q;
      mem_be_o    = be_q[NB-1:0];
      mem_wdata_o = wdata_q;
    end else if (state_q == S_REQ1) begin
      mem_req_o   = 1'b1;
      mem_we_o    = wr_q;
      mem_addr_o  = base_q + ADDR_W'(NB);
      mem_be_o    = be_q[2*NB-1:NB];
      mem_wdata_o = wdata_q;
    end
  end

endmodule

// File: tb/tb_yarp_lsu.sv
// tb/tb_yarp_lsu.sv - directed self-checking bench for yarp_lsu
module tb_yarp_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lsu_req = 1'b0;
  logic        lsu_req_na = 1'b0;
  logic        lsu_wr = 1'b0;
  logic [1:0]  lsu_size = 2'b00;
  logic        lsu_zext = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        busy, done, err, mreq, mwe;
  logic [31:0] rdata, maddr, mwdata;
  logic [3:0]  mbe;

  logic        busy_na, done_na, err_na, mreq_na, mwe_na;
  logic [31:0] rdata_na, maddr_na, mwdata_na;
  logic [3:0]  mbe_na;

  int n_checks = 0;
  int n_fail = 0;

  yarp_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .lsu_req_i(lsu_req), .lsu_wr_i(lsu_wr), .lsu_size_i(lsu_size),
    .lsu_zero_extnd_i(lsu_zext), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_busy_o(busy), .lsu_done_o(done), .lsu_err_o(err), .lsu_rdata_o(rdata),
    .mem_req_o(mreq), .mem_gnt_i(mem_gnt), .mem_we_o(mwe), .mem_addr_o(maddr),
    .mem_be_o(mbe), .mem_wdata_o(mwdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  yarp_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
    .clk(clk), .reset(reset),
    .lsu_req_i(lsu_req_na), .lsu_wr_i(lsu_wr), .lsu_size_i(lsu_size),
    .lsu_zero_extnd_i(lsu_zext), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_busy_o(busy_na), .lsu_done_o(done_na), .lsu_err_o(err_na), .lsu_rdata_o(rdata_na),
    .mem_req_o(mreq_na), .mem_gnt_i(mem_gnt), .mem_we_o(mwe_na), .mem_addr_o(maddr_na),
    .mem_be_o(mbe_na), .mem_wdata_o(mwdata_na), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Results of the last run_access
  int          r_done_cyc;
  logic [31:0] r_rdata;
  logic        r_err;
  int          r_nbeats;
  logic        r_stable;
  logic        r_busy_ok;
  logic        r_we;
  logic [31:0] r_addr [2];
  logic [3:0]  r_be [2];
  logic [31:0] r_wdata [2];
  logic        r_done_after;
  logic        r_busy_after;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one access at the current cycle (cycle 0) and act as the bus
  task automatic run_access(input logic wr, input logic [1:0] sz, input logic zx,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input int gnt_delay);
    int waited;
    int beat;
    bit pend;
    bit seen [2];
    r_done_cyc = -1; r_rdata = '0; r_err = 1'b0; r_nbeats = 0;
    r_stable = 1'b1; r_busy_ok = 1'b1; r_we = 1'b0;
    for (int b = 0; b < 2; b++) begin
      r_addr[b] = '0; r_be[b] = '0; r_wdata[b] = '0; seen[b] = 1'b0;
    end
    waited = 0; beat = 0; pend = 1'b0;
    lsu_req = 1'b1; lsu_wr = wr; lsu_size = sz; lsu_zext = zx;
    lsu_addr = addr; lsu_wdata = wd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (done) begin
        r_done_cyc = cyc; r_rdata = rdata; r_err = err;
        break;
      end
      if (!busy) r_busy_ok = 1'b0;
      if (mreq) begin
        if (beat < 2) begin
          if (!seen[beat]) begin
            seen[beat] = 1'b1;
            r_addr[beat] = maddr; r_be[beat] = mbe; r_wdata[beat] = mwdata;
            r_we = mwe; r_nbeats++;
          end else if (maddr !== r_addr[beat] || mbe !== r_be[beat] ||
                       mwdata !== r_wdata[beat] || mwe !== r_we) begin
            r_stable = 1'b0;
          end
        end
        if (waited >= gnt_delay) begin
          mem_gnt = 1'b1; pend = 1'b1; waited = 0;
        end else begin
          waited++;
        end
      end else if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata = (beat == 0) ? rd0 : rd1;
        beat++;
        pend = 1'b0;
      end
    end
    @(posedge clk); #1;
    r_done_after = done; r_busy_after = busy;
  endtask

  initial begin
    // Reset
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mreq", 32'(mreq), 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_mbe", 32'(mbe), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;

    // LW aligned, minimum latency
    run_access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0);
    chk("lw_addr", r_addr[0], 32'h100);
    chk("lw_be", 32'(r_be[0]), 32'hF);
    chk("lw_we", 32'(r_we), 32'd0);
    chk("lw_beats", 32'(r_nbeats), 32'd1);
    chk("lw_done_cyc", 32'(r_done_cyc), 32'd3);
    chk("lw_rdata", r_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(r_err), 32'd0);
    chk("lw_done_after", 32'(r_done_after), 32'd0);
    chk("lw_busy_after", 32'(r_busy_after), 32'd0);

    // LB sign- and zero-extended from lane 3
    run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 32'h0, 0);
    chk("lb_be", 32'(r_be[0]), 32'h8);
    chk("lb_addr", r_addr[0], 32'h100);
    chk("lb_sext", r_rdata, 32'hFFFFFF80);
    run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 32'h0, 0);
    chk("lb_zext", r_rdata, 32'h00000080);

    // SW split across a word boundary
    run_access(1'b1, 2'b11, 1'b0, 32'h0FE, 32'h11223344, 32'h0, 32'h0, 0);
    chk("sw_b0_addr", r_addr[0], 32'h0FC);
    chk("sw_b0_be", 32'(r_be[0]), 32'hC);
    chk("sw_b0_wdata", r_wdata[0], 32'h33441122);
    chk("sw_b1_addr", r_addr[1], 32'h100);
    chk("sw_b1_be", 32'(r_be[1]), 32'h3);
    chk("sw_b1_wdata", r_wdata[1], 32'h33441122);
    chk("sw_we", 32'(r_we), 32'd1);
    chk("sw_beats", 32'(r_nbeats), 32'd2);
    chk("sw_done_cyc", 32'(r_done_cyc), 32'd5);
    chk("sw_rdata", r_rdata, 32'd0);

    // LH split, sign-extended
    run_access(1'b0, 2'b01, 1'b0, 32'h0FF, 32'h0, 32'h34000000, 32'h00000092, 0);
    chk("lh_b0_be", 32'(r_be[0]), 32'h8);
    chk("lh_b1_be", 32'(r_be[1]), 32'h1);
    chk("lh_b1_addr", r_addr[1], 32'h100);
    chk("lh_rdata", r_rdata, 32'hFFFF9234);
    chk("lh_done_cyc", 32'(r_done_cyc), 32'd5);

    // Same LH on the misaligned-forbidden instance
    lsu_wr = 1'b0; lsu_size = 2'b01; lsu_zext = 1'b0; lsu_addr = 32'h0FF;
    lsu_req_na = 1'b1;
    @(posedge clk); #1;
    lsu_req_na = 1'b0;
    chk("na_done", 32'(done_na), 32'd1);
    chk("na_err", 32'(err_na), 32'd1);
    chk("na_mreq", 32'(mreq_na), 32'd0);
    chk("na_rdata", rdata_na, 32'd0);
    @(posedge clk); #1;
    chk("na_done_after", 32'(done_na), 32'd0);
    chk("na_busy_after", 32'(busy_na), 32'd0);

    // Grant held off for 5 cycles
    run_access(1'b1, 2'b11, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0, 32'h0, 5);
    chk("stall_stable", 32'(r_stable), 32'd1);
    chk("stall_busy", 32'(r_busy_ok), 32'd1);
    chk("stall_addr", r_addr[0], 32'h104);
    chk("stall_wdata", r_wdata[0], 32'hCAFEF00D);
    chk("stall_done_cyc", 32'(r_done_cyc), 32'd8);

    // Dword size is illegal at XLEN=32
    run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 0);
    chk("dw_done_cyc", 32'(r_done_cyc), 32'd1);
    chk("dw_err", 32'(r_err), 32'd1);
    chk("dw_beats", 32'(r_nbeats), 32'd0);
    chk("dw_rdata", r_rdata, 32'd0);

    // Split store wrapping the top of the address space
    run_access(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000ABCD, 32'h0, 32'h0, 0);
    chk("wrap_b0_addr", r_addr[0], 32'hFFFFFFFC);
    chk("wrap_b0_be", 32'(r_be[0]), 32'h8);
    chk("wrap_b1_addr", r_addr[1], 32'h0);
    chk("wrap_b1_be", 32'(r_be[1]), 32'h1);
    chk("wrap_wdata", r_wdata[1], 32'hCD0000AB);

    // Reset while waiting for rvalid, then a stale rvalid
    lsu_req = 1'b1; lsu_wr = 1'b0; lsu_size = 2'b11; lsu_zext = 1'b0; lsu_addr = 32'h200;
    @(posedge clk); #1;
    lsu_req = 1'b0;
    chk("rstmid_mreq", 32'(mreq), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rstmid_wait", 32'({busy, mreq}), 32'b10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_mreq0", 32'(mreq), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("stale_done", 32'(done), 32'd0);
    chk("stale_busy", 32'(busy), 32'd0);
    chk("stale_rdata", rdata, 32'd0);
    run_access(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 32'h12345678, 32'h0, 0);
    chk("post_done_cyc", 32'(r_done_cyc), 32'd3);
    chk("post_rdata", r_rdata, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
